// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - frame states and framing constants for uart_frame_arbiter
package uart_frame_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    HDR1,
    HDR2,
    FETCH,
    BODY,
    TRL1,
    TRL2,
    FIN
  } frame_state_t;

  localparam logic [7:0] FRAME_SIGN  = 8'h26;
  localparam int         MAX_LEN_DEF = 137;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot pick, searching from ptr upward with wrap
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - shares one uart_tx byte engine among requesters, wrapping each payload as && payload &&
module uart_frame_arbiter
  import uart_frame_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          MAX_LEN     = MAX_LEN_DEF,
  parameter logic [23:0] TIMEOUT_CLK = 24'd2_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] len_i,
  input  logic [NUM_REQ*8-1:0] byte_i,
  output logic [7:0]           rd_idx,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 busy,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_req,
  input  logic                 uart_tx_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  frame_state_t       state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [7:0]         len_q;
  logic [23:0]        tmo_cnt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   rr_next;
  logic [7:0]         arb_len;
  logic [7:0]         len_clamped;
  logic [7:0]         win_byte;
  logic               more_body;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    arb_idx  = '0;
    arb_len  = '0;
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        arb_idx = PTR_W'(k);
        arb_len = len_i[k*8 +: 8];
      end
      if (win_idx == PTR_W'(k)) begin
        win_byte = byte_i[k*8 +: 8];
      end
    end
  end

  assign len_clamped = (int'(arb_len) > MAX_LEN) ? 8'(MAX_LEN) : arb_len;
  // The winner moves to the back of the queue for the next arbitration.
  assign rr_next     = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + PTR_W'(1);
  assign more_body   = ({1'b0, rd_idx} + 9'd1) < {1'b0, len_q};
  assign busy        = (state != IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      win_idx      <= '0;
      len_q        <= '0;
      tmo_cnt      <= '0;
      rd_idx       <= '0;
      grant        <= '0;
      done         <= '0;
      err          <= 1'b0;
      uart_tx_data <= '0;
      uart_tx_req  <= 1'b0;
    end else begin
      done        <= '0;
      err         <= 1'b0;
      uart_tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i != '0) state <= ARB;
        end
        ARB: begin
          if (arb_gnt == '0) begin
            state <= IDLE;
          end else begin
            win_idx      <= arb_idx;
            rr_ptr       <= rr_next;
            len_q        <= len_clamped;
            rd_idx       <= '0;
            grant        <= arb_gnt;
            uart_tx_data <= FRAME_SIGN;
            uart_tx_req  <= 1'b1;
            tmo_cnt      <= '0;
            state        <= HDR1;
          end
        end
        FETCH: begin
          uart_tx_data <= win_byte;
          uart_tx_req  <= 1'b1;
          tmo_cnt      <= '0;
          state        <= BODY;
        end
        FIN: begin
          done  <= grant;
          grant <= '0;
          state <= IDLE;
        end
        HDR1, HDR2, BODY, TRL1, TRL2: begin
          if (uart_tx_done) begin
            tmo_cnt <= '0;
            case (state)
              HDR1: begin
                uart_tx_data <= FRAME_SIGN;
                uart_tx_req  <= 1'b1;
                state        <= HDR2;
              end
              HDR2: begin
                if (len_q != '0) begin
                  state <= FETCH;
                end else begin
                  uart_tx_data <= FRAME_SIGN;
                  uart_tx_req  <= 1'b1;
                  state        <= TRL1;
                end
              end
              BODY: begin
                if (more_body) begin
                  rd_idx <= rd_idx + 8'd1;
                  state  <= FETCH;
                end else begin
                  uart_tx_data <= FRAME_SIGN;
                  uart_tx_req  <= 1'b1;
                  state        <= TRL1;
                end
              end
              TRL1: begin
                uart_tx_data <= FRAME_SIGN;
                uart_tx_req  <= 1'b1;
                state        <= TRL2;
              end
              default: state <= FIN;
            endcase
          end else if (tmo_cnt >= TIMEOUT_CLK - 24'd1) begin
            // The byte engine went silent: drop the frame without a done.
            err     <= 1'b1;
            grant   <= '0;
            rd_idx  <= '0;
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb/tb_uart_frame_arbiter.sv - self-checking bench for uart_frame_arbiter
module tb_uart_frame_arbiter;

  localparam int NREQ = 4;
  localparam int MAXL = 137;
  localparam int TMO  = 40;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req_i;
  logic [31:0] len_i;
  logic [31:0] byte_i;
  logic [7:0]  rd_idx;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_req;
  logic        uart_tx_done = 1'b0;

  logic [7:0]  pay [NREQ][256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_seen = 0;
  int          hold_at = -1;
  int          pend = 0;
  int          mptr = 0;
  logic        inject_done = 1'b0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] len;
    int         win;
    int         exp_len;
  } vec_t;
  vec_t tv [8];

  uart_frame_arbiter #(
    .NUM_REQ     (NREQ),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CLK (24'(TMO))
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req_i        (req_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .rd_idx       (rd_idx),
    .grant        (grant),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .uart_tx_data (uart_tx_data),
    .uart_tx_req  (uart_tx_req),
    .uart_tx_done (uart_tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NREQ; k++) begin : g_pay
    assign byte_i[k*8 +: 8] = pay[k][rd_idx];
  end

  // Byte engine stand-in: answers each request after 1..3 cycles unless told to stay silent.
  always @(negedge sys_clk) begin
    uart_tx_done = 1'b0;
    if (inject_done) begin
      uart_tx_done = 1'b1;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) uart_tx_done = 1'b1;
    end
    if (uart_tx_req) begin
      req_seen++;
      if (req_seen != hold_at) pend = $urandom_range(1, 3);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic at_edge();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic expect_frame(input string nm, input int w, input int l, input bit drop, output int waitn);
    logic [7:0] got [$];
    logic [7:0] expb;
    logic [3:0] eg;
    logic [3:0] dval;
    logic [3:0] gend;
    int gbad;
    int rbad;
    int ebad;
    int bbad;
    int nb;
    bit started;
    eg = 4'(1 << w);
    dval = '0;
    gend = '1;
    gbad = 0;
    rbad = 0;
    ebad = 0;
    bbad = 0;
    started = 1'b0;
    waitn = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      if (!started) begin
        waitn++;
        if (grant != '0) begin
          started = 1'b1;
          chk({nm, " grant"}, 32'(grant), 32'(eg));
          if (drop) req_i = '0;
        end else if (waitn > 20) begin
          break;
        end
      end
      if (started) begin
        if (uart_tx_req) begin
          nb = got.size();
          if (l == 0) begin
            if (rd_idx != 8'd0) rbad++;
          end else if (nb >= 2 && nb < l + 2 && int'(rd_idx) != nb - 2) begin
            rbad++;
          end
          got.push_back(uart_tx_data);
        end
        if (err) ebad++;
        if (done != '0) begin
          dval = done;
          gend = grant;
          break;
        end
        if (grant != eg) gbad++;
      end
    end
    chk({nm, " started"}, 32'(started), 32'd1);
    chk({nm, " nbytes"}, got.size(), l + 4);
    for (int j = 0; j < got.size(); j++) begin
      if (j < 2 || j >= l + 2) expb = 8'h26;
      else expb = pay[w][j-2];
      if (got[j] !== expb) bbad++;
    end
    chk({nm, " byte_errors"}, bbad, 0);
    chk({nm, " done"}, 32'(dval), 32'(eg));
    chk({nm, " grant_cleared"}, 32'(gend), 32'd0);
    chk({nm, " grant_stable"}, gbad, 0);
    chk({nm, " rd_idx"}, rbad, 0);
    chk({nm, " no_err"}, ebad, 0);
    @(negedge sys_clk);
    chk({nm, " done_once"}, 32'(done), 32'd0);
    mptr = (w + 1) % NREQ;
  endtask

  initial begin
    int wn;
    int bad;
    int k0;
    int last_req;
    int err_cyc;
    int nbytes;
    int dseen;
    bit gseen;
    logic [3:0] gerr;
    logic berr;
    logic [3:0] r;
    int lens [NREQ];
    int nfr;
    int w;
    int l;

    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < 256; i++) pay[k][i] = 8'(8'h41 + 16 * k + i);
    end
    // Winner and clamped length follow from the round-robin order after the single-request frame (pointer at 1).
    tv[0] = '{4'b0100, 8'd0,   2, 0};
    tv[1] = '{4'b1111, 8'd5,   3, 5};
    tv[2] = '{4'b0110, 8'd200, 1, 137};
    tv[3] = '{4'b0011, 8'd137, 0, 137};
    tv[4] = '{4'b1001, 8'd255, 3, 137};
    tv[5] = '{4'b1110, 8'd1,   1, 1};
    tv[6] = '{4'b0010, 8'd138, 1, 137};
    tv[7] = '{4'b0101, 8'd2,   2, 2};

    sys_rst = 1'b1;
    req_i   = '0;
    len_i   = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs", 32'({grant, done, err, busy, uart_tx_req, uart_tx_data, rd_idx}), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    at_edge();
    req_i = 4'b0001;
    len_i = {4{8'd3}};
    @(negedge sys_clk);
    chk("lat_cycle0_idle", 32'(busy), 32'd0);
    @(negedge sys_clk);
    chk("lat_cycle1_arb", 32'({busy, uart_tx_req, grant}), 32'b1_0_0000);
    expect_frame("single", 0, 3, 1'b1, wn);
    chk("lat_first_req_cycle2", wn, 1);

    for (int i = 0; i < 8; i++) begin
      at_edge();
      req_i = tv[i].req;
      len_i = {4{tv[i].len}};
      expect_frame($sformatf("vec%0d", i), tv[i].win, tv[i].exp_len, 1'b1, wn);
    end

    at_edge();
    req_i = 4'b0001;
    len_i = {4{8'd10}};
    k0 = req_seen;
    for (int c = 0; c < 200 && req_seen < k0 + 5; c++) at_edge();
    chk("rst_reached_body", 32'(req_seen >= k0 + 5), 32'd1);
    #2;
    sys_rst = 1'b1;
    req_i   = '0;
    #1;
    chk("rst_async_outputs", 32'({grant, done, err, busy, uart_tx_req, uart_tx_data, rd_idx}), 32'd0);
    bad = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (done != '0 || err || busy) bad++;
    end
    chk("rst_no_pulse", bad, 0);
    sys_rst = 1'b0;
    mptr = 0;

    at_edge();
    req_i = 4'b1011;
    len_i = {4{8'd2}};
    expect_frame("cont0", 0, 2, 1'b0, wn);
    expect_frame("cont1", 1, 2, 1'b0, wn);
    expect_frame("cont2", 3, 2, 1'b0, wn);
    expect_frame("cont3", 0, 2, 1'b1, wn);

    at_edge();
    inject_done = 1'b1;
    at_edge();
    inject_done = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge sys_clk);
      if (busy || uart_tx_req || grant != '0) bad++;
    end
    chk("stray_done_ignored", bad, 0);

    at_edge();
    hold_at  = req_seen + 3;
    req_i    = 4'b0100;
    len_i    = {4{8'd4}};
    last_req = -1;
    err_cyc  = -1;
    nbytes   = 0;
    dseen    = 0;
    gseen    = 1'b0;
    gerr     = '1;
    berr     = 1'b1;
    for (int c = 0; c < TMO + 100; c++) begin
      @(negedge sys_clk);
      if (grant != '0 && !gseen) begin
        gseen = 1'b1;
        req_i = '0;
      end
      if (uart_tx_req) begin
        last_req = cyc;
        nbytes++;
      end
      if (done != '0) dseen++;
      if (err) begin
        err_cyc = cyc;
        gerr    = grant;
        berr    = busy;
        break;
      end
    end
    chk("tmo_latency", err_cyc - last_req, TMO);
    chk("tmo_bytes", nbytes, 3);
    chk("tmo_no_done", dseen, 0);
    chk("tmo_idle", 32'({gerr, berr}), 32'd0);
    @(negedge sys_clk);
    chk("tmo_err_pulse", 32'(err), 32'd0);
    at_edge();
    hold_at = -1;
    mptr = 3;
    req_i = 4'b0001;
    len_i = {4{8'd2}};
    expect_frame("after_tmo", 0, 2, 1'b1, wn);

    for (int ep = 0; ep < 25; ep++) begin
      r = 4'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 7) == 0) lens[k] = $urandom_range(130, 255);
        else lens[k] = $urandom_range(0, 9);
      end
      nfr = $urandom_range(1, 3);
      at_edge();
      req_i = r;
      len_i = {8'(lens[3]), 8'(lens[2]), 8'(lens[1]), 8'(lens[0])};
      for (int f = 0; f < nfr; f++) begin
        w = rr_pick(r, mptr);
        l = (lens[w] > MAXL) ? MAXL : lens[w];
        expect_frame($sformatf("rnd%0d_%0d", ep, f), w, l, f == nfr - 1, wn);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
